f2c_ring_dma: RTL and testbench
===============================

Name: f2c_ring_dma

Overview:
- FPGA-to-host (F2C) DMA engine that streams 64-bit source data into a host-memory circular buffer of 2^SLOT_BITS slots, TLP_QWS quadwords per slot.
- After each payload write it posts its write pointer to a host mailbox at the end of the ring.
- Generalises the fixed 16-slot/16-QW F2C scheme: slot count, TLP size and buffer depth are parametrised; the block adds full-ring back-pressure, graceful disable and a TLP counter.
- Sits between the application source stream and the TLP transmit path of the PCIe core.

Parameters:
- SLOT_BITS, 4: log2 of ring slot count; 1..8.
- TLP_QWS, 16: QWs per slot/TLP; power of two, 1..32 (payload ≤ 256 bytes).
- FIFO_DEPTH, 32: internal source FIFO depth in QWs; power of two, ≥ TLP_QWS.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  asynchronous active-high reset
- enable_in  in  1  DMA enable (register DMA_ENABLE)
- base_in  in  32  host byte base address of ring (register F2C_BASE); aligned to TLP_QWS*8
- rdPtr_in  in  SLOT_BITS  host read pointer value
- rdPtrWrite_in  in  1  strobe: latch rdPtr_in (register F2C_RDPTR write)
- srcData_in  in  64  source QW
- srcValid_in  in  1  source valid
- srcReady_out  out  1  source ready (FIFO not full)
- mwrAddr_out  out  32  host byte address of current MWr; stable for whole burst
- mwrData_out  out  64  MWr payload QW
- mwrFirst_out  out  1  first beat of MWr
- mwrLast_out  out  1  last beat of MWr
- mwrValid_out  out  1  beat valid
- mwrReady_in  in  1  beat accepted when valid&ready
- wrPtr_out  out  SLOT_BITS  current write pointer
- tlpCount_out  out  32  payload TLPs completed since reset; wraps at 2^32
- busy_out  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; FIFO empty; wrPtr=0; rdPtr reg=0; tlpCount=0; all outputs 0 (srcReady_out=0 during reset, 1 from the first clock after).
- rdPtr reg is loaded on any cycle rdPtrWrite_in=1, in all states.
- Ring full when ((wrPtr+1) mod 2^SLOT_BITS) == rdPtr; one slot is always left empty.
- FIFO accepts a QW on srcValid_in&srcReady_out regardless of enable. Simultaneous push and pop on a full FIFO is not allowed (srcReady_out=0 when full).
- IDLE:
  - if enable_in=0: hold, and clear wrPtr to 0.
  - else if FIFO level ≥ TLP_QWS and ring not full: go to BURST next cycle.
- BURST:
  - mwrAddr_out = base_in + wrPtr*TLP_QWS*8; base_in is sampled on BURST entry.
  - Emit exactly TLP_QWS beats from the FIFO, with mwrValid_out continuously high (FIFO pre-filled, no bubbles).
  - First beat carries mwrFirst_out; beat TLP_QWS-1 carries mwrLast_out.
  - On the last accepted beat: wrPtr increments mod 2^SLOT_BITS, tlpCount increments, go to PTR.
- PTR:
  - Single-beat MWr (first=last=1).
  - Address = base_in + 2^SLOT_BITS*TLP_QWS*8; data = zero-extended new wrPtr.
  - On accept: go to IDLE.
- Latency: first burst beat valid exactly 1 cycle after the IDLE entry condition is true. Min cycles per slot = TLP_QWS+2 with mwrReady_in tied high.
- enable_in falling mid-BURST or mid-PTR: the current burst and pointer update complete; the block then returns to IDLE and stalls. FIFO contents are retained.
- Address arithmetic is 32-bit and wraps silently; the ring plus mailbox must not cross 4 GB (software's responsibility).

Test Plan:
- Reset default: assert reset_in mid-BURST -> all outputs 0 immediately, wrPtr_out=0, tlpCount_out=0; after release with enable=1 and no source data, no MWr is issued.
- Basic stream (defaults): base=0, enable=1, push 256 incrementing QWs, host echoes rdPtr after each TLP -> 16 payload MWrs at 0x000, 0x080 … 0x780 with matching data, each followed by a mailbox MWr at 0x800 with data 1..15,0.
- Full ring: rdPtr held at 0, push 20 TLPs of data -> exactly 15 payload MWrs, wrPtr_out=15, srcReady_out=0 once the FIFO fills; write rdPtr=1 -> exactly one further payload at slot 15, then wrPtr_out=0.
- Back-pressure: mwrReady_in toggled pseudo-randomly -> mwrAddr_out/mwrData_out stable while valid&!ready; beat count per TLP exactly TLP_QWS.
- Disable mid-burst: drop enable_in on beat 3 -> burst completes 16 beats plus pointer MWr, busy_out falls, then no further MWr; re-enable -> wrPtr restarts at 0.
- Parametrised: SLOT_BITS=2, TLP_QWS=4, base=0x1000 -> payload addresses 0x1000/0x1020/0x1040, mailbox at 0x1080, full after 3 TLPs.

Source files
------------

// File: rtl/f2c_ring_dma.sv
// f2c_ring_dma: FPGA-to-host DMA engine. Streams 64-bit source QWs into a
// host circular buffer of 2^SLOT_BITS slots (TLP_QWS QWs per slot), posting
// the updated write pointer to a mailbox just past the ring after each slot.
module f2c_ring_dma #(
  parameter int unsigned SLOT_BITS  = 4,
  parameter int unsigned TLP_QWS    = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic [31:0]          base_in,
  input  logic [SLOT_BITS-1:0] rdPtr_in,
  input  logic                 rdPtrWrite_in,
  input  logic [63:0]          srcData_in,
  input  logic                 srcValid_in,
  output logic                 srcReady_out,
  output logic [31:0]          mwrAddr_out,
  output logic [63:0]          mwrData_out,
  output logic                 mwrFirst_out,
  output logic                 mwrLast_out,
  output logic                 mwrValid_out,
  input  logic                 mwrReady_in,
  output logic [SLOT_BITS-1:0] wrPtr_out,
  output logic [31:0]          tlpCount_out,
  output logic                 busy_out
);

  localparam int unsigned AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW          = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW          = (TLP_QWS > 1) ? $clog2(TLP_QWS) : 1;
  localparam int unsigned ADDR_SHIFT  = $clog2(TLP_QWS) + 3;
  localparam logic [31:0] MBOX_OFFSET = 32'(1) << (SLOT_BITS + ADDR_SHIFT);

  typedef enum logic [1:0] {IDLE, BURST, PTR} state_t;

  state_t                state, state_nxt;
  logic [63:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [LW-1:0]         fifo_level;
  logic                  fifo_full;
  logic                  rdy_q;
  logic                  push, pop;
  logic                  burst_start, burst_done;
  logic [BW-1:0]         beat;
  logic [31:0]           base_q;
  logic [SLOT_BITS-1:0]  wr_ptr, rd_ptr, wr_ptr_inc;
  logic [31:0]           tlp_cnt;
  logic                  ring_full;

  assign fifo_full    = (fifo_level == LW'(FIFO_DEPTH));
  assign srcReady_out = rdy_q & ~fifo_full;
  assign push         = srcValid_in & srcReady_out;
  assign wr_ptr_inc   = wr_ptr + 1'b1;
  assign ring_full    = (wr_ptr_inc == rd_ptr);
  assign wrPtr_out    = wr_ptr;
  assign tlpCount_out = tlp_cnt;

  // Source FIFO storage (no reset needed; occupancy is tracked separately)
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_idx] <= srcData_in;
  end

  // Source FIFO pointers, occupancy and the post-reset ready enable
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_level <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_idx <= (wr_idx == AW'(FIFO_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      if (pop)  rd_idx <= (rd_idx == AW'(FIFO_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and MWr beat outputs; outputs are zero outside BURST/PTR
  always_comb begin
    state_nxt    = state;
    mwrValid_out = 1'b0;
    mwrFirst_out = 1'b0;
    mwrLast_out  = 1'b0;
    mwrAddr_out  = '0;
    mwrData_out  = '0;
    pop          = 1'b0;
    burst_start  = 1'b0;
    burst_done   = 1'b0;
    busy_out     = (state != IDLE);
    case (state)
      IDLE: begin
        if (enable_in && (fifo_level >= LW'(TLP_QWS)) && !ring_full) begin
          state_nxt   = BURST;
          burst_start = 1'b1;
        end
      end
      BURST: begin
        mwrValid_out = 1'b1;
        mwrFirst_out = (beat == '0);
        mwrLast_out  = (beat == BW'(TLP_QWS - 1));
        mwrAddr_out  = base_q + (32'(wr_ptr) << ADDR_SHIFT);
        mwrData_out  = mem[rd_idx];
        if (mwrReady_in) begin
          pop = 1'b1;
          if (mwrLast_out) begin
            burst_done = 1'b1;
            state_nxt  = PTR;
          end
        end
      end
      PTR: begin
        mwrValid_out = 1'b1;
        mwrFirst_out = 1'b1;
        mwrLast_out  = 1'b1;
        mwrAddr_out  = base_q + MBOX_OFFSET;
        mwrData_out  = 64'(wr_ptr);
        if (mwrReady_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: base capture, beat index, ring pointers, TLP counter
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      base_q  <= '0;
      beat    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tlp_cnt <= '0;
    end else begin
      if (rdPtrWrite_in) rd_ptr <= rdPtr_in;
      if (burst_start) begin
        base_q <= base_in;
        beat   <= '0;
      end else if (pop) begin
        beat <= beat + 1'b1;
      end
      if (state == IDLE && !enable_in) wr_ptr <= '0;
      else if (burst_done)             wr_ptr <= wr_ptr_inc;
      if (burst_done) tlp_cnt <= tlp_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_f2c_ring_dma.sv
// Randomised bench for f2c_ring_dma: a queue-based host/ring model checks
// every accepted MWr beat of a default-parameter instance, plus a directed
// run of a small-ring instance (SLOT_BITS=2, TLP_QWS=4).
module tb_f2c_ring_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default-parameter instance
  logic        enable, rd_wr, src_valid, src_ready, mwr_first, mwr_last;
  logic        mwr_valid, mwr_ready, busy;
  logic [31:0] base, mwr_addr, tlp_count;
  logic [3:0]  rd_ptr, wr_ptr;
  logic [63:0] src_data, mwr_data;

  f2c_ring_dma dut (
    .clk_in(clk), .reset_in(rst), .enable_in(enable), .base_in(base),
    .rdPtr_in(rd_ptr), .rdPtrWrite_in(rd_wr), .srcData_in(src_data),
    .srcValid_in(src_valid), .srcReady_out(src_ready), .mwrAddr_out(mwr_addr),
    .mwrData_out(mwr_data), .mwrFirst_out(mwr_first), .mwrLast_out(mwr_last),
    .mwrValid_out(mwr_valid), .mwrReady_in(mwr_ready), .wrPtr_out(wr_ptr),
    .tlpCount_out(tlp_count), .busy_out(busy)
  );

  // Small-ring instance
  logic        b_en, b_src_valid, b_src_ready, b_first, b_last, b_valid, b_busy;
  logic [31:0] b_addr, b_tlp;
  logic [1:0]  b_wr_ptr;
  logic [63:0] b_src_data, b_data;

  f2c_ring_dma #(.SLOT_BITS(2), .TLP_QWS(4), .FIFO_DEPTH(8)) dut_b (
    .clk_in(clk), .reset_in(rst), .enable_in(b_en), .base_in(32'h0000_1000),
    .rdPtr_in(2'd0), .rdPtrWrite_in(1'b0), .srcData_in(b_src_data),
    .srcValid_in(b_src_valid), .srcReady_out(b_src_ready), .mwrAddr_out(b_addr),
    .mwrData_out(b_data), .mwrFirst_out(b_first), .mwrLast_out(b_last),
    .mwrValid_out(b_valid), .mwrReady_in(1'b1), .wrPtr_out(b_wr_ptr),
    .tlpCount_out(b_tlp), .busy_out(b_busy)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0] exp_q[$];
  int unsigned m_slot = 0, m_idx = 0, m_tlp = 0, pushed = 0, push_target = 0;
  int unsigned beats_total = 0;
  bit          m_in_ptr = 0, echo_mode = 0, echo_pend = 0, bp_mode = 0, hold_v = 0;
  logic [3:0]  echo_val;
  logic [31:0] cur_base = '0, hold_a;
  logic [63:0] hold_d;

  typedef struct {logic [31:0] a; logic [63:0] d; logic f; logic l;} beat_t;
  beat_t       b_q[$];
  int unsigned b_pushed = 0, b_target = 0;

  // Monitor: record pushes and check every accepted MWr against the ring model
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (src_valid && src_ready) begin
        exp_q.push_back(src_data);
        pushed++;
      end
      if (hold_v && mwr_valid) begin
        check("stable_addr", 64'(mwr_addr), 64'(hold_a));
        check("stable_data", mwr_data, hold_d);
      end
      hold_v = mwr_valid && !mwr_ready;
      hold_a = mwr_addr;
      hold_d = mwr_data;
      if (mwr_valid && mwr_ready) begin
        beats_total++;
        if (!m_in_ptr) begin
          if (exp_q.size() > 0) check("pay_data", mwr_data, exp_q.pop_front());
          else                  check("pay_queue_depth", 64'(exp_q.size()), 64'd1);
          check("pay_addr", 64'(mwr_addr), 64'(cur_base + 32'(m_slot) * 32'd128));
          check("pay_first", 64'(mwr_first), 64'(m_idx == 0));
          check("pay_last", 64'(mwr_last), 64'(m_idx == 15));
          m_idx++;
          if (m_idx == 16) begin
            m_idx = 0;
            m_slot = (m_slot + 1) % 16;
            m_tlp++;
            m_in_ptr = 1;
          end
        end else begin
          check("mbox_addr", 64'(mwr_addr), 64'(cur_base + 32'h800));
          check("mbox_data", mwr_data, 64'(m_slot));
          check("mbox_first_last", 64'({mwr_first, mwr_last}), 64'd3);
          check("tlp_count", 64'(tlp_count), 64'(m_tlp));
          check("wr_ptr", 64'(wr_ptr), 64'(m_slot));
          m_in_ptr = 0;
          if (echo_mode) begin
            echo_pend = 1;
            echo_val = 4'(m_slot);
          end
        end
      end
      if (!busy && !enable) m_slot = 0;
      if (b_src_valid && b_src_ready) b_pushed++;
      if (b_valid) b_q.push_back('{b_addr, b_data, b_first, b_last});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    src_valid = (pushed < push_target) && ($urandom_range(0, 3) != 0);
    src_data  = {$urandom, $urandom};
    mwr_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (echo_pend) begin
      rd_ptr = echo_val;
      rd_wr = 1'b1;
      echo_pend = 0;
    end else begin
      rd_wr = 1'b0;
    end
    b_src_valid = (b_pushed < b_target);
    b_src_data  = 64'(b_pushed);
  endtask

  task automatic write_rd(input logic [3:0] v);
    rd_ptr = v;
    rd_wr = 1'b1;
    step();
  endtask

  function automatic bit drained();
    return (pushed >= push_target) && (exp_q.size() < 16) && !busy && !m_in_ptr;
  endfunction

  task automatic run_drain(input int unsigned max_cycles);
    for (int unsigned i = 0; i < max_cycles; i++) begin
      if (drained()) break;
      step();
    end
    check("drain_done", 64'(drained()), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned saved_tlp, saved_beats;
    int unsigned guard;
    rst = 1'b1; enable = 1'b0; base = '0; rd_ptr = '0; rd_wr = 1'b0;
    src_valid = 1'b0; src_data = '0; mwr_ready = 1'b1;
    b_en = 1'b0; b_src_valid = 1'b0; b_src_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(mwr_valid), 64'd0);
    check("rst_addr", 64'(mwr_addr), 64'd0);
    check("rst_data", mwr_data, 64'd0);
    check("rst_src_ready", 64'(src_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("rst_tlp", 64'(tlp_count), 64'd0);
    rst = 1'b0;
    step();
    check("src_ready_after_rst", 64'(src_ready), 64'd1);

    // Small ring: three payloads then full (rdPtr stays 0)
    b_en = 1'b1;
    b_target = 16;
    repeat (80) step();
    check("b_beats", 64'(b_q.size()), 64'd15);
    check("b_wr_ptr", 64'(b_wr_ptr), 64'd3);
    check("b_tlp", 64'(b_tlp), 64'd3);
    if (b_q.size() == 15) begin
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 4; k++) begin
          check("b_pay_addr", 64'(b_q[j*5+k].a), 64'(32'h1000 + 32'(j) * 32'h20));
          check("b_pay_data", b_q[j*5+k].d, 64'(4 * j + k));
          check("b_pay_fl", 64'({b_q[j*5+k].f, b_q[j*5+k].l}), 64'({k == 0, k == 3}));
        end
        check("b_mbox_addr", 64'(b_q[j*5+4].a), 64'h1080);
        check("b_mbox_data", b_q[j*5+4].d, 64'(j + 1));
      end
    end
    b_en = 1'b0;

    // Asynchronous reset in the middle of a burst
    enable = 1'b1;
    push_target = pushed + 16;
    guard = 0;
    while (m_idx < 3 && guard < 200) begin
      step();
      guard++;
    end
    check("reach_mid_burst", 64'(m_idx >= 3), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(mwr_valid), 64'd0);
    check("midrst_addr", 64'(mwr_addr), 64'd0);
    check("midrst_data", mwr_data, 64'd0);
    check("midrst_first_last", 64'({mwr_first, mwr_last}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_src_ready", 64'(src_ready), 64'd0);
    check("midrst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("midrst_tlp", 64'(tlp_count), 64'd0);
    exp_q.delete();
    m_slot = 0; m_idx = 0; m_in_ptr = 0; m_tlp = 0;
    push_target = pushed;
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    saved_beats = beats_total;
    repeat (30) step();
    check("no_mwr_without_data", 64'(beats_total), 64'(saved_beats));

    // Basic stream with host echoing the pointer
    echo_mode = 1;
    push_target = pushed + 256;
    run_drain(3000);
    check("basic_tlp", 64'(tlp_count), 64'd16);
    check("basic_wr_ptr", 64'(wr_ptr), 64'd0);

    // Full ring: rdPtr held at 0
    echo_mode = 0;
    push_target = pushed + 320;
    repeat (700) step();
    check("full_tlp", 64'(tlp_count), 64'd31);
    check("full_wr_ptr", 64'(wr_ptr), 64'd15);
    check("full_src_ready", 64'(src_ready), 64'd0);
    check("full_fifo_level", 64'(exp_q.size()), 64'd32);
    write_rd(4'd1);
    repeat (60) step();
    check("full_release_tlp", 64'(tlp_count), 64'd32);
    check("full_release_wr_ptr", 64'(wr_ptr), 64'd0);

    // Back-pressure with random ready
    push_target = pushed;
    write_rd(4'd0);
    echo_mode = 1;
    bp_mode = 1;
    push_target = pushed + 96;
    run_drain(4000);
    check("bp_tlp", 64'(tlp_count), 64'd40);
    check("bp_fifo_left", 64'(exp_q.size()), 64'd0);
    bp_mode = 0;

    // Disable on beat 3, new base
    base = 32'h1234_5680;
    cur_base = 32'h1234_5680;
    push_target = pushed + 32;
    guard = 0;
    while (!(m_idx == 3 && !m_in_ptr) && guard < 300) begin
      step();
      guard++;
    end
    check("reach_beat3", 64'(m_idx), 64'd3);
    enable = 1'b0;
    saved_tlp = m_tlp;
    repeat (40) step();
    saved_beats = beats_total;
    repeat (20) step();
    check("dis_tlp", 64'(tlp_count), 64'(saved_tlp + 1));
    check("dis_busy", 64'(busy), 64'd0);
    check("dis_wr_ptr", 64'(wr_ptr), 64'd0);
    check("dis_no_more_mwr", 64'(beats_total), 64'(saved_beats));
    check("dis_fifo_kept", 64'(exp_q.size()), 64'd16);
    write_rd(4'd0);
    enable = 1'b1;
    run_drain(300);
    check("reen_tlp", 64'(tlp_count), 64'(saved_tlp + 2));
    check("reen_wr_ptr", 64'(wr_ptr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
